// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage: 32x32 register file, ALU control decode and a registered
// valid/ready output bundle. Define ALU_OPERAND_STAGE_BYPASS_EN to forward same-cycle writebacks.
module alu_operand_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_s,
   output logic [DATA_W-1:0] alu_t,
   output logic [3:0]        alu_control,
   output logic [ADDR_W-1:0] out_dest,
   output logic              out_illegal
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   regFile_q [2**ADDR_W];
   logic [DATA_W-1:0]   aluS_q, aluS_d;
   logic [DATA_W-1:0]   aluT_q, aluT_d;
   logic [3:0]          aluControl_q, aluControl_d;
   logic [ADDR_W-1:0]   outDest_q, outDest_d;
   logic                outIllegal_q, outIllegal_d;
   logic                accept;
   logic                wbActive;
   logic [DATA_W-1:0]   rsVal, rtVal, immExt;
   logic                useImm, signExt;

   assign in_ready = (state_q == EMPTY) || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign wbActive = wb_en && (wb_addr != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2**ADDR_W; i++) regFile_q[i] <= '0;
      end else if (wbActive) begin
         regFile_q[wb_addr] <= wb_data;
      end
   end

`ifdef ALU_OPERAND_STAGE_BYPASS_EN
   // A writeback landing in the accept cycle is forwarded into the captured operand.
   assign rsVal = (rs == '0) ? '0 : ((wbActive && wb_addr == rs) ? wb_data : regFile_q[rs]);
   assign rtVal = (rt == '0) ? '0 : ((wbActive && wb_addr == rt) ? wb_data : regFile_q[rt]);
`else
   assign rsVal = (rs == '0) ? '0 : regFile_q[rs];
   assign rtVal = (rt == '0) ? '0 : regFile_q[rt];
`endif

   assign immExt = signExt ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};

   always_comb begin
      aluControl_d = 4'hF;
      outIllegal_d = 1'b0;
      outDest_d    = '0;
      useImm       = 1'b0;
      signExt      = 1'b1;
      if (opcode == 6'h00) begin
         outDest_d = rd;
         case (funct)
            6'h20, 6'h21: aluControl_d = 4'h2;
            6'h22, 6'h23: aluControl_d = 4'h6;
            6'h24:        aluControl_d = 4'h0;
            6'h25:        aluControl_d = 4'h1;
            6'h27:        aluControl_d = 4'hC;
            6'h2A:        aluControl_d = 4'h7;
            default: begin
               outIllegal_d = 1'b1;
               outDest_d    = '0;
            end
         endcase
      end else begin
         outDest_d = rt;
         useImm    = 1'b1;
         case (opcode)
            6'h08, 6'h09, 6'h23: aluControl_d = 4'h2;
            6'h0A:               aluControl_d = 4'h7;
            6'h0C: begin
               aluControl_d = 4'h0;
               signExt      = 1'b0;
            end
            6'h0D: begin
               aluControl_d = 4'h1;
               signExt      = 1'b0;
            end
            6'h2B: begin
               aluControl_d = 4'h2;
               outDest_d    = '0;
            end
            6'h04: begin
               aluControl_d = 4'h6;
               useImm       = 1'b0;
               outDest_d    = '0;
            end
            default: begin
               outIllegal_d = 1'b1;
               outDest_d    = '0;
               useImm       = 1'b0;
            end
         endcase
      end
      aluS_d = rsVal;
      aluT_d = useImm ? immExt : rtVal;
   end

   // Flush wins over everything but reset; otherwise a consumed bundle empties the stage.
   always_comb begin
      state_d = state_q;
      if (flush)          state_d = EMPTY;
      else if (accept)    state_d = FULL;
      else if (out_ready) state_d = EMPTY;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= EMPTY;
         aluS_q       <= '0;
         aluT_q       <= '0;
         aluControl_q <= '0;
         outDest_q    <= '0;
         outIllegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            aluS_q       <= aluS_d;
            aluT_q       <= aluT_d;
            aluControl_q <= aluControl_d;
            outDest_q    <= outDest_d;
            outIllegal_q <= outIllegal_d;
         end
      end
   end

   assign out_valid   = (state_q == FULL);
   assign alu_s       = aluS_q;
   assign alu_t       = aluT_q;
   assign alu_control = aluControl_q;
   assign out_dest    = outDest_q;
   assign out_illegal = outIllegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a reference decode/register model predicts each
// accepted bundle, which is compared while the stage holds it.
module tb_alu_operand_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [5:0]  opcode = '0, funct = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic [15:0] imm = '0;
   logic        flush = 1'b0, wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] alu_s, alu_t;
   logic [3:0]  alu_control;
   logic [4:0]  out_dest;
   logic        out_illegal;

   typedef struct {
      logic [31:0] s;
      logic [31:0] t;
      logic [3:0]  ctrl;
      logic [4:0]  dest;
      logic        illegal;
   } bundle_t;

   bundle_t     expQ[$];
   bundle_t     expFront;
   logic [31:0] modelRegs [32];
   logic        modelFull = 1'b0;
   logic        modelReady, modelAccept;
   int          testsRun = 0;
   int          testsFailed = 0;

   alu_operand_stage dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_s(alu_s), .alu_t(alu_t),
      .alu_control(alu_control), .out_dest(out_dest), .out_illegal(out_illegal)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] readModel(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef ALU_OPERAND_STAGE_BYPASS_EN
      if (wb_en && wb_addr == a) return wb_data;
`endif
      return modelRegs[a];
   endfunction

   // Reference decode written from the instruction tables, independent of the RTL structure.
   function automatic bundle_t predict();
      bundle_t b;
      logic [31:0] sx, zx;
      sx = {{16{imm[15]}}, imm};
      zx = {16'h0000, imm};
      b.s = readModel(rs);
      b.t = readModel(rt);
      b.illegal = 1'b0;
      b.ctrl = 4'hF;
      b.dest = rt;
      if (opcode == 6'h00) begin
         b.dest = rd;
         case (funct)
            6'h20, 6'h21: b.ctrl = 4'h2;
            6'h22, 6'h23: b.ctrl = 4'h6;
            6'h24: b.ctrl = 4'h0;
            6'h25: b.ctrl = 4'h1;
            6'h27: b.ctrl = 4'hC;
            6'h2A: b.ctrl = 4'h7;
            default: b.illegal = 1'b1;
         endcase
      end else begin
         case (opcode)
            6'h08, 6'h09: begin b.ctrl = 4'h2; b.t = sx; end
            6'h0A: begin b.ctrl = 4'h7; b.t = sx; end
            6'h0C: begin b.ctrl = 4'h0; b.t = zx; end
            6'h0D: begin b.ctrl = 4'h1; b.t = zx; end
            6'h23: begin b.ctrl = 4'h2; b.t = sx; end
            6'h2B: begin b.ctrl = 4'h2; b.t = sx; b.dest = 5'd0; end
            6'h04: begin b.ctrl = 4'h6; b.dest = 5'd0; end
            default: b.illegal = 1'b1;
         endcase
      end
      if (b.illegal) begin
         b.ctrl = 4'hF;
         b.dest = 5'd0;
      end
      return b;
   endfunction

   // Mid-cycle monitor: checks the held bundle against the scoreboard, then advances the model.
   always @(negedge clock) begin
      if (!reset) begin
         checkOutput("out_valid", {31'd0, out_valid}, {31'd0, modelFull});
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !modelFull || out_ready});
         if (modelFull && expQ.size() > 0) begin
            expFront = expQ[0];
            checkOutput("alu_s", alu_s, expFront.s);
            checkOutput("alu_t", alu_t, expFront.t);
            checkOutput("alu_control", {28'd0, alu_control}, {28'd0, expFront.ctrl});
            checkOutput("out_dest", {27'd0, out_dest}, {27'd0, expFront.dest});
            checkOutput("out_illegal", {31'd0, out_illegal}, {31'd0, expFront.illegal});
         end
      end
      if (reset) begin
         expQ.delete();
         modelFull = 1'b0;
         for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
      end else begin
         modelReady  = !modelFull || out_ready;
         modelAccept = in_valid && modelReady && !flush;
         if (flush) begin
            expQ.delete();
            modelFull = 1'b0;
         end else begin
            if (modelFull && out_ready && expQ.size() > 0) void'(expQ.pop_front());
            if (modelAccept) expQ.push_back(predict());
            modelFull = modelAccept ? 1'b1 : (out_ready ? 1'b0 : modelFull);
         end
         if (wb_en && wb_addr != 5'd0) modelRegs[wb_addr] = wb_data;
      end
   end

   task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] d, input logic [5:0] fn,
                                input logic [15:0] im, input logic ordy, input logic fl,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd);
      in_valid = v; opcode = op; rs = s; rt = t; rd = d; funct = fn; imm = im;
      out_ready = ordy; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
      @(posedge clock);
      #1;
   endtask

   task automatic rInstr(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] fn);
      applyStimulus(1'b1, 6'h00, s, t, d, fn, {d, 5'd0, fn}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic iInstr(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
      applyStimulus(1'b1, op, s, t, 5'd0, im[5:0], im, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
      applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   logic [5:0] opTable [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h09};
   logic [5:0] fnTable [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h23};

   initial begin
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("reset_s", alu_s, 32'd0);
      checkOutput("reset_t", alu_t, 32'd0);
      checkOutput("reset_ctrl", {28'd0, alu_control}, 32'd0);

      rInstr(5'd3, 5'd4, 5'd5, 6'h20);
      checkOutput("add_dest", {27'd0, out_dest}, 32'd5);
      checkOutput("add_ctrl", {28'd0, alu_control}, 32'd2);

      writeReg(5'd1, 32'h0000F000);
      iInstr(6'h0D, 5'd1, 5'd2, 16'h8001);
      checkOutput("ori_s", alu_s, 32'h0000F000);
      checkOutput("ori_t", alu_t, 32'h00008001);
      checkOutput("ori_ctrl", {28'd0, alu_control}, 32'd1);
      iInstr(6'h08, 5'd1, 5'd3, 16'hFFFF);
      checkOutput("addi_t", alu_t, 32'hFFFFFFFF);
      checkOutput("addi_ctrl", {28'd0, alu_control}, 32'd2);

      writeReg(5'd3, 32'h80000001);
      writeReg(5'd4, 32'h00FF00FF);
      for (int i = 0; i < 8; i++) rInstr(5'd3, 5'd4, 5'd9, fnTable[i]);
      iInstr(6'h0C, 5'd3, 5'd6, 16'h8000);
      iInstr(6'h0A, 5'd3, 5'd6, 16'h8000);
      iInstr(6'h23, 5'd4, 5'd6, 16'h0010);
      iInstr(6'h2B, 5'd4, 5'd6, 16'hFFF0);
      iInstr(6'h04, 5'd3, 5'd4, 16'h0004);

      // Stall: bundle held, nothing accepted, then accepted on release.
      rInstr(5'd1, 5'd3, 5'd10, 6'h25);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 6'h00, 5'd4, 5'd1, 5'd11, 6'h22, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
         checkOutput("stall_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("stall_dest", {27'd0, out_dest}, 32'd10);
      end
      applyStimulus(1'b1, 6'h00, 5'd4, 5'd1, 5'd11, 6'h22, 16'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      checkOutput("release_dest", {27'd0, out_dest}, 32'd11);

      writeReg(5'd0, 32'hDEADBEEF);
      rInstr(5'd0, 5'd1, 5'd12, 6'h20);
      checkOutput("r0_s", alu_s, 32'd0);
      rInstr(5'd1, 5'd1, 5'd12, 6'h3F);
      checkOutput("illegal_flag", {31'd0, out_illegal}, 32'd1);
      checkOutput("illegal_ctrl", {28'd0, alu_control}, 32'hF);
      checkOutput("illegal_dest", {27'd0, out_dest}, 32'd0);

      applyStimulus(1'b1, 6'h00, 5'd7, 5'd0, 5'd8, 6'h2A, 16'h0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678);
`ifdef ALU_OPERAND_STAGE_BYPASS_EN
      checkOutput("bypass_s", alu_s, 32'h12345678);
`else
      checkOutput("bypass_s", alu_s, 32'd0);
`endif
      rInstr(5'd7, 5'd0, 5'd8, 6'h20);
      checkOutput("after_wb_s", alu_s, 32'h12345678);

      // Flush while FULL with a new instruction offered.
      applyStimulus(1'b1, 6'h00, 5'd7, 5'd7, 5'd13, 6'h20, 16'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
      idle(2);

      // Reset during a stall.
      rInstr(5'd1, 5'd7, 5'd14, 6'h24);
      applyStimulus(1'b1, 6'h00, 5'd3, 5'd4, 5'd15, 6'h20, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      reset = 1'b1;
      applyStimulus(1'b1, 6'h00, 5'd3, 5'd4, 5'd15, 6'h20, 16'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55);
      reset = 1'b0;
      checkOutput("rst_stall_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_stall_s", alu_s, 32'd0);
      checkOutput("rst_stall_dest", {27'd0, out_dest}, 32'd0);
      rInstr(5'd1, 5'd7, 5'd16, 6'h20);
      checkOutput("rst_regs_s", alu_s, 32'd0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), opTable[$urandom_range(0, 11)],
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       fnTable[$urandom_range(0, 7)], 16'($urandom()),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
      end
      idle(3);
      checkOutput("final_valid", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode/operand-fetch stage directly upstream of `alu_32`. Holds the 32×32 MIPS register file, decodes opcode/funct into the 4-bit ALU control code, and selects the second operand: register or extended immediate. It presents a registered `alu_s`/`alu_t`/`alu_control` bundle to the ALU under a valid/ready handshake. It also accepts the writeback port from the downstream stages.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; fixed at 32 because the decoder depends on it.
- `ADDR_W`, 5, register address width; fixed at 5.

Ports:
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: instruction fields below are valid.
- `in_ready` out 1: stage can accept this cycle.
- `opcode` in 6: instruction [31:26].
- `rs` in 5: instruction [25:21].
- `rt` in 5: instruction [20:16].
- `rd` in 5: instruction [15:11].
- `funct` in 6: instruction [5:0].
- `imm` in 16: instruction [15:0].
- `flush` in 1: discard held and incoming instruction.
- `wb_en` in 1: register file write enable.
- `wb_addr` in 5: write address.
- `wb_data` in 32: write data.
- `out_valid` out 1: output bundle valid.
- `out_ready` in 1: ALU side consumes the bundle.
- `alu_s` out 32: ALU operand s, which is R[rs].
- `alu_t` out 32: ALU operand t, which is R[rt] or the extended immediate.
- `alu_control` out 4: ALU op code.
- `out_dest` out 5: destination register; 0 means no write.
- `out_illegal` out 1: instruction not decodable.

## Operation
- Register file:
  - 32 entries.
  - Writes with `wb_en=1` and `wb_addr=0` are ignored.
  - Reads of register 0 always return 0.
- Decode, R-type (`opcode=0x00`), selected by `funct`:
  - 0x20/0x21 → control 2 (add).
  - 0x22/0x23 → control 6 (sub).
  - 0x24 → control 0 (and).
  - 0x25 → control 1 (or).
  - 0x27 → control C (nor).
  - 0x2A → control 7 (slt).
  - R-type: `alu_t`=R[rt], `out_dest`=`rd`.
- Decode, I-type, selected by `opcode`:
  - addi/addiu 0x08/0x09 → 2, sign-extended imm.
  - slti 0x0A → 7, sign-extended.
  - andi 0x0C → 0, zero-extended.
  - ori 0x0D → 1, zero-extended.
  - lw 0x23 → 2, sign-extended.
  - sw 0x2B → 2, sign-extended, `out_dest`=0.
  - beq 0x04 → 6, `alu_t`=R[rt], `out_dest`=0.
  - All other I-type: `out_dest`=`rt`.
- Any other opcode/funct combination:
  - `out_illegal`=1, `alu_control`=4'hF, `out_dest`=0.
  - Operands are still loaded; the illegal bundle is still handshaken out.
- Output-register state machine:
  - States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - `in_ready` = !`out_valid` || `out_ready` (combinational). Accept = `in_valid` && `in_ready` && !`flush`.
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with `out_ready`: bundle replaced.
  - FULL → FULL when `out_ready`=0: bundle held stable, no input accepted.
  - FULL → EMPTY on `out_ready` without accept.
  - `flush`=1 → EMPTY next cycle regardless of other inputs; the incoming instruction is dropped.
- Operands are sampled at acceptance only. A writeback landing while FULL does not update a held bundle.
- Simultaneous writeback and read of the same nonzero register: behaviour set by the configuration macro (see Configuration).

## Timing
- Latency: 1 cycle; an instruction accepted at edge N appears on the outputs after edge N.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Registered outputs: all `alu_*`, `out_dest`, `out_illegal` and `out_valid`.
- Register file write takes effect at the edge where `wb_en`=1.
- Reset (synchronous, takes priority over flush, accept and writeback):
  - `out_valid`=0 and all registered outputs 0.
  - All 32 registers cleared to 0.
  - `in_ready`=1 after reset.
- Reset mid-stall: the held bundle is lost.

## Configuration
- `ALU_OPERAND_STAGE_BYPASS_EN` defined:
  - When `wb_en`=1 and `wb_addr` is nonzero and equals `rs` or `rt` in the accept cycle, the captured operand is `wb_data`.
- Undefined:
  - The captured operand is the pre-write register contents.
  - The written value is visible only to instructions accepted on later cycles.

## Test plan
- **Reset:** assert `reset`, then R-type add `rs=3 rt=4 rd=5` → `alu_s`=0, `alu_t`=0, `alu_control`=2, `out_dest`=5, `out_valid` one cycle after accept.
- **ori:** write R1=0x0000F000, then ori `rs=1 imm=0x8001` → `alu_s`=0x0000F000, `alu_t`=0x00008001, `alu_control`=1. Then addi `imm=0xFFFF` → `alu_t`=0xFFFFFFFF, `alu_control`=2.
- **Stall:** `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs unchanged. Release → next instruction accepted the same cycle.
- **Register 0:** write R0=0xDEADBEEF, then read rs=0 → `alu_s`=0. Illegal funct 0x3F → `out_illegal`=1, `alu_control`=F, `out_dest`=0.
- **Bypass:** `wb_en` with R7=0x12345678 in the same cycle as accept of slt `rs=7` → `alu_s`=0x12345678 with the macro, old value 0 without it.
- **Flush:** `flush` with FULL and `in_valid`=1 → `out_valid`=0 next cycle, the incoming instruction is never output. `reset` during a stall → `out_valid`=0, all outputs 0.
